wfg_wb_arbiter: RTL and testbench
=================================

WFG_WB_ARBITER -- requirements
Module: wfg_wb_arbiter

Interface
REQ-001 SHALL have parameter AW, 32, Wishbone address width.
REQ-002 SHALL have parameter DW, 32, Wishbone data width.
REQ-003 SHALL have parameter TIMEOUT, 255, max wait cycles for slave ack (legal 1..1023).
REQ-004 SHALL have one clock and an asynchronous active-low reset, named as in the rest of the wfg Wishbone logic: io_wbs_clk  in  1  clock (rising edge); io_wbs_rst  in  1  asynchronous active-low reset.
REQ-005 SHALL have, for each master mN (N=0 Caravel bus, N=1 secondary config loader): mN_cyc in 1, mN_stb in 1, mN_we in 1, mN_adr in AW, mN_datwr in DW, mN_sel in DW/8 (request side); mN_ack out 1, mN_err out 1, mN_datrd out DW (response side).
REQ-006 SHALL have slave side toward wfg_top: s_cyc out 1, s_stb out 1, s_we out 1, s_adr out AW, s_datwr out DW, s_sel out DW/8, s_ack in 1, s_datrd in DW.

Function
REQ-007 SHALL implement FSM states IDLE, GNT0, GNT1; a master requests when mN_cyc&mN_stb.
REQ-008 IDLE: one request -> grant that master; both -> grant master not granted last (last_grant register); none -> stay IDLE.
REQ-009 Grant SHALL be registered: a request seen in IDLE at edge k drives the slave from edge k onward (one-cycle arbitration latency).
REQ-010 In GNTn, s_cyc/s_stb/s_we/s_adr/s_datwr/s_sel SHALL equal master n's inputs combinationally; in IDLE all slave outputs SHALL be 0.
REQ-011 In GNTn, mn_ack=s_ack and mn_datrd=s_datrd; the non-granted master's ack, err, datrd SHALL be 0.
REQ-012 GNTn SHALL hold while mn_cyc=1 (multi-beat cycles not interleaved) and return to IDLE the cycle after mn_cyc=0; last_grant<=n on that exit.
REQ-013 A waiting counter (width clog2(TIMEOUT+1)) SHALL increment each cycle s_stb=1 and s_ack=0, clear on s_ack=1 or in IDLE.
REQ-014 When counter==TIMEOUT and s_ack=0, arbiter SHALL assert mn_err for exactly one cycle, force s_stb=0 that cycle, clear counter; grant stays until mn_cyc=0.
REQ-015 s_ack=1 in the same cycle the counter reaches TIMEOUT SHALL take precedence: ack delivered, no err.
REQ-016 Requests arriving while the other master is granted SHALL wait with no ack/err; no request is dropped.
REQ-017 mN_ack and mN_err SHALL never both be 1 in a cycle.

Reset
REQ-018 io_wbs_rst=0 SHALL immediately force state IDLE, counter 0, last_grant=1 (m0 wins first tie), all outputs 0, including mid-transaction.
REQ-019 Deassertion is synchronised externally; first arbitration occurs on the first rising edge after release.

Structure
REQ-020 State enum (IDLE/GNT0/GNT1) and default AW/DW/TIMEOUT constants SHALL live in shared package wfg_pkg.
REQ-021 Timeout counter SHALL be sub-module wfg_wb_timeout (inputs en, clr; output expired); all else inline.
REQ-022 RTL target 150-300 lines; wfg_top instantiated unchanged behind s_* ports.

Verification
REQ-023 Single master: m0 write adr=0x30000004 dat=0xDEADBEEF, slave acks after 2 cycles -> s_adr/s_datwr match, m0_ack one cycle, m1_ack=0.
REQ-024 Tie: m0 and m1 request same cycle after reset -> m0 granted first, m1 granted the cycle after m0 drops cyc; next tie -> m1 first.
REQ-025 Timeout: TIMEOUT=8, slave never acks -> m0_err exactly one cycle 8 cycles after s_stb rose, s_stb low that cycle, no m0_ack.
REQ-026 Ack at timeout edge: slave acks on cycle counter==TIMEOUT -> m0_ack=1, m0_err=0.
REQ-027 Reset mid-cycle: assert io_wbs_rst while GNT1 with s_stb=1 -> all outputs 0 asynchronously, state IDLE, next tie goes to m0.
REQ-028 Read with held grant: m1 does 3 back-to-back reads (cyc held) returning 0x1,0x2,0x3 -> m1_datrd matches each ack, m0 request meanwhile waits, granted after m1_cyc falls.

Source files
------------

// File: rtl/wfg_pkg.sv
// Shared types and defaults for the wfg Wishbone arbitration logic.
package wfg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } wb_arb_state_t;

    localparam int WB_AW_DEF      = 32;
    localparam int WB_DW_DEF      = 32;
    localparam int WB_TIMEOUT_DEF = 255;

    // Counter width able to hold the value TIMEOUT itself.
    function automatic int wb_cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wfg_wb_timeout.sv
// Slave-wait counter: counts stalled strobe cycles and flags when TIMEOUT is reached.
module wfg_wb_timeout
    import wfg_pkg::*;
#(
    parameter int TIMEOUT = WB_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int CW = wb_cnt_width(TIMEOUT);

    logic [CW-1:0] r_count;

    // Wait counter; clear has priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + CW'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign expired = (r_count == CW'(TIMEOUT));

endmodule

// File: rtl/wfg_wb_arbiter.sv
// Two-master Wishbone arbiter in front of wfg_top: round-robin on ties,
// grant held for a whole cycle, and a slave-ack timeout that answers with err.
module wfg_wb_arbiter
    import wfg_pkg::*;
#(
    parameter int AW      = WB_AW_DEF,
    parameter int DW      = WB_DW_DEF,
    parameter int TIMEOUT = WB_TIMEOUT_DEF
) (
    input  logic            io_wbs_clk,
    input  logic            io_wbs_rst,
    input  logic            m0_cyc,
    input  logic            m0_stb,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_adr,
    input  logic [DW-1:0]   m0_datwr,
    input  logic [DW/8-1:0] m0_sel,
    output logic            m0_ack,
    output logic            m0_err,
    output logic [DW-1:0]   m0_datrd,
    input  logic            m1_cyc,
    input  logic            m1_stb,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_adr,
    input  logic [DW-1:0]   m1_datwr,
    input  logic [DW/8-1:0] m1_sel,
    output logic            m1_ack,
    output logic            m1_err,
    output logic [DW-1:0]   m1_datrd,
    output logic            s_cyc,
    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    output logic [DW-1:0]   s_datwr,
    output logic [DW/8-1:0] s_sel,
    input  logic            s_ack,
    input  logic [DW-1:0]   s_datrd
);

    wb_arb_state_t r_state;
    logic          r_last_grant;
    logic          w_req0;
    logic          w_req1;
    logic          w_stb_raw;
    logic          w_expired;
    logic          w_timeout_err;

    assign w_req0 = m0_cyc & m0_stb;
    assign w_req1 = m1_cyc & m1_stb;

    assign w_stb_raw = (r_state == GNT0) ? m0_stb :
                       (r_state == GNT1) ? m1_stb : 1'b0;

    // A late ack in the expiry cycle wins, so err only fires without ack.
    assign w_timeout_err = (r_state != IDLE) & w_expired & ~s_ack;

    wfg_wb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (io_wbs_clk),
        .rst_n   (io_wbs_rst),
        .en      (w_stb_raw & ~s_ack),
        .clr     ((r_state == IDLE) | s_ack | w_expired),
        .expired (w_expired)
    );

    // Grant FSM; a grant persists until its master drops cyc.
    always_ff @(posedge io_wbs_clk or negedge io_wbs_rst) begin
        if (!io_wbs_rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req0 && w_req1) begin
                        r_state <= r_last_grant ? GNT0 : GNT1;
                    end else if (w_req0) begin
                        r_state <= GNT0;
                    end else if (w_req1) begin
                        r_state <= GNT1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                GNT0: begin
                    if (!m0_cyc) begin
                        r_state      <= IDLE;
                        r_last_grant <= 1'b0;
                    end
                end
                GNT1: begin
                    if (!m1_cyc) begin
                        r_state      <= IDLE;
                        r_last_grant <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Bus steering: granted master routed straight through, everything else zero.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_datwr  = '0;
        s_sel    = '0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_datrd = '0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_datrd = '0;
        case (r_state)
            GNT0: begin
                s_cyc    = m0_cyc;
                s_stb    = m0_stb & ~w_timeout_err;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_datwr  = m0_datwr;
                s_sel    = m0_sel;
                m0_ack   = s_ack;
                m0_err   = w_timeout_err;
                m0_datrd = s_datrd;
            end
            GNT1: begin
                s_cyc    = m1_cyc;
                s_stb    = m1_stb & ~w_timeout_err;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_datwr  = m1_datwr;
                s_sel    = m1_sel;
                m1_ack   = s_ack;
                m1_err   = w_timeout_err;
                m1_datrd = s_datrd;
            end
            default: begin
                s_cyc = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_wfg_wb_arbiter.sv
// Bench for wfg_wb_arbiter: arbitration table, directed corner sequences and
// random traffic, all compared against a transaction-level ownership model.
module tb_wfg_wb_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam logic [31:0] ADR0 = 32'h3000_0004;
    localparam logic [31:0] ADR1 = 32'h3000_0100;

    logic            io_wbs_clk = 1'b0;
    logic            io_wbs_rst = 1'b0;
    logic            m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
    logic [AW-1:0]   m0_adr;
    logic [DW-1:0]   m0_datwr, m0_datrd;
    logic [DW/8-1:0] m0_sel;
    logic            m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
    logic [AW-1:0]   m1_adr;
    logic [DW-1:0]   m1_datwr, m1_datrd;
    logic [DW/8-1:0] m1_sel;
    logic            s_cyc, s_stb, s_we, s_ack;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_datwr, s_datrd;
    logic [DW/8-1:0] s_sel;

    int total = 0;
    int bad   = 0;
    // Reference model: who owns the bus, who won last, how long the slave has stalled.
    int own;
    int last;
    int waitc;

    typedef struct {
        bit c0;
        bit c1;
        bit ack;
        int own;
        bit a0;
        bit a1;
    } vec_t;

    wfg_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .io_wbs_clk (io_wbs_clk), .io_wbs_rst (io_wbs_rst),
        .m0_cyc (m0_cyc), .m0_stb (m0_stb), .m0_we (m0_we), .m0_adr (m0_adr),
        .m0_datwr (m0_datwr), .m0_sel (m0_sel), .m0_ack (m0_ack), .m0_err (m0_err),
        .m0_datrd (m0_datrd),
        .m1_cyc (m1_cyc), .m1_stb (m1_stb), .m1_we (m1_we), .m1_adr (m1_adr),
        .m1_datwr (m1_datwr), .m1_sel (m1_sel), .m1_ack (m1_ack), .m1_err (m1_err),
        .m1_datrd (m1_datrd),
        .s_cyc (s_cyc), .s_stb (s_stb), .s_we (s_we), .s_adr (s_adr),
        .s_datwr (s_datwr), .s_sel (s_sel), .s_ack (s_ack), .s_datrd (s_datrd)
    );

    always #5 io_wbs_clk = ~io_wbs_clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = ADR0; m0_datwr = '0; m0_sel = 4'hF;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = ADR1; m1_datwr = '0; m1_sel = 4'hF;
        s_ack = 1'b0; s_datrd = '0;
    endtask

    function automatic bit model_timeout();
        return (own >= 0) && (waitc == TO) && !s_ack;
    endfunction

    // Compare every DUT output with what the model says the current cycle should show.
    task automatic model_check();
        logic [70:0] es;
        logic [33:0] e0, e1;
        bit          te;
        te = model_timeout();
        es = '0; e0 = '0; e1 = '0;
        if (own == 0) begin
            es = {m0_cyc, m0_stb & ~te, m0_we, m0_adr, m0_datwr, m0_sel};
            e0 = {s_ack, te, s_datrd};
        end else if (own == 1) begin
            es = {m1_cyc, m1_stb & ~te, m1_we, m1_adr, m1_datwr, m1_sel};
            e1 = {s_ack, te, s_datrd};
        end
        chk("model.slave", {s_cyc, s_stb, s_we, s_adr, s_datwr, s_sel}, es);
        chk("model.m0", {m0_ack, m0_err, m0_datrd}, e0);
        chk("model.m1", {m1_ack, m1_err, m1_datrd}, e1);
    endtask

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_step();
        bit r0, r1, cyc, stb;
        r0 = m0_cyc & m0_stb;
        r1 = m1_cyc & m1_stb;
        if (own < 0) begin
            waitc = 0;
            if (r0 && r1) own = (last == 1) ? 0 : 1;
            else if (r0) own = 0;
            else if (r1) own = 1;
        end else begin
            cyc = (own == 0) ? m0_cyc : m1_cyc;
            stb = (own == 0) ? m0_stb : m1_stb;
            if (s_ack || waitc == TO) waitc = 0;
            else if (stb) waitc++;
            if (!cyc) begin
                last = own;
                own  = -1;
            end
        end
    endtask

    task automatic settle();
        @(negedge io_wbs_clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge io_wbs_clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        io_wbs_rst = 1'b0;
        idle_inputs();
        own = -1; last = 1; waitc = 0;
        #1;
        chk("rst.slave", {s_cyc, s_stb, s_we, s_adr, s_datwr, s_sel}, '0);
        chk("rst.masters", {m0_ack, m0_err, m0_datrd, m1_ack, m1_err, m1_datrd}, '0);
        repeat (2) @(posedge io_wbs_clk);
        @(negedge io_wbs_clk);
        io_wbs_rst = 1'b1;
        advance();
    endtask

    initial begin
        vec_t tbl [15];
        logic [31:0] want_adr;

        tbl = '{
            '{1'b1, 1'b1, 1'b0, -1, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1,  0, 1'b1, 1'b0},
            '{1'b0, 1'b1, 1'b0,  0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1,  1, 1'b0, 1'b1},
            '{1'b1, 1'b0, 1'b0,  1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0,  0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0,  1, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b0, -1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0,  0, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b0, -1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b1,  1, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0}
        };

        do_reset();

        // Arbitration table: ties, alternation, one-cycle latency through IDLE.
        for (int i = 0; i < 15; i++) begin
            m0_cyc = tbl[i].c0; m0_stb = tbl[i].c0;
            m1_cyc = tbl[i].c1; m1_stb = tbl[i].c1;
            s_ack  = tbl[i].ack; s_datrd = 32'h100 + i;
            want_adr = (tbl[i].own == 0) ? ADR0 : (tbl[i].own == 1) ? ADR1 : 32'h0;
            settle();
            chk($sformatf("tbl[%0d].adr", i), s_adr, want_adr);
            chk($sformatf("tbl[%0d].ack", i), {m0_ack, m1_ack}, {tbl[i].a0, tbl[i].a1});
            advance();
        end

        // Single write, slave acks two cycles after the grant.
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h3000_0004; m0_datwr = 32'hDEAD_BEEF;
        settle(); chk("wr.idle_stb", s_stb, 1'b0); advance();
        for (int j = 0; j < 3; j++) begin
            s_ack = (j == 2);
            settle();
            chk("wr.adr", {s_we, s_adr, s_datwr}, {1'b1, 32'h3000_0004, 32'hDEAD_BEEF});
            chk("wr.ack", {m0_ack, m1_ack}, {(j == 2), 1'b0});
            advance();
        end
        m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
        settle(); chk("wr.ack_gone", m0_ack, 1'b0); advance();

        // Slave never answers: one err beat exactly TO cycles after strobe rises.
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1;
        settle(); advance();
        for (int j = 0; j <= TO; j++) begin
            settle();
            chk("to.err", m0_err, (j == TO));
            chk("to.stb", s_stb, (j != TO));
            chk("to.ack", m0_ack, 1'b0);
            advance();
        end
        m0_cyc = 1'b0; m0_stb = 1'b0;
        settle(); advance();

        // Ack in the expiry cycle beats the timeout.
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1;
        settle(); advance();
        for (int j = 0; j <= TO; j++) begin
            s_ack = (j == TO);
            settle();
            chk("edge.ack_err", {m0_ack, m0_err}, {(j == TO), 1'b0});
            advance();
        end
        m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
        settle(); advance();

        // Async reset while m1 owns the bus, then the next tie goes to m0.
        do_reset();
        m1_cyc = 1'b1; m1_stb = 1'b1; s_ack = 1'b1; s_datrd = 32'h5555_AAAA;
        settle(); advance();
        settle(); chk("mrst.gnt1_stb", s_stb, 1'b1);
        #2 io_wbs_rst = 1'b0;
        #1;
        chk("mrst.outs", {s_cyc, s_stb, s_adr, m1_ack, m1_datrd, m0_ack}, '0);
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        settle(); advance();
        settle(); chk("mrst.tie_m0", s_adr, ADR0); advance();
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        settle(); advance();

        // Three reads under one m1 cycle while m0 waits.
        do_reset();
        m1_cyc = 1'b1; m1_stb = 1'b1;
        settle(); advance();
        m0_cyc = 1'b1; m0_stb = 1'b1;
        for (int j = 0; j < 4; j++) begin
            s_ack   = (j != 1);
            s_datrd = (j == 0) ? 32'h1 : (j == 2) ? 32'h2 : (j == 3) ? 32'h3 : 32'hFFFF;
            settle();
            if (j != 1) chk("rd.datrd", {m1_ack, m1_datrd}, {1'b1, s_datrd});
            chk("rd.m0_wait", {m0_ack, m0_err}, 2'b00);
            advance();
        end
        m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
        settle(); advance();
        settle(); chk("rd.m0_idle", s_cyc, 1'b0); advance();
        settle(); chk("rd.m0_gnt", s_adr, ADR0); advance();
        m0_cyc = 1'b0; m0_stb = 1'b0;
        settle(); advance();

        // Random traffic against the model; slow slave so timeouts occur.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            m0_cyc = ($urandom_range(0, 9) < 7); m0_stb = ($urandom_range(0, 9) < 7);
            m1_cyc = ($urandom_range(0, 9) < 7); m1_stb = ($urandom_range(0, 9) < 7);
            m0_we = $urandom_range(0, 1); m1_we = $urandom_range(0, 1);
            m0_adr = $urandom; m1_adr = $urandom; m0_datwr = $urandom; m1_datwr = $urandom;
            m0_sel = 4'($urandom); m1_sel = 4'($urandom);
            s_ack = ($urandom_range(0, 11) == 0); s_datrd = $urandom;
            settle();
            chk("rnd.ack_err_excl", {m0_ack & m0_err, m1_ack & m1_err}, 2'b00);
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
